race_sequencer: RTL and testbench

//  Game-flow controller for the racer. Consumes decoded key events from the PS/2 keyboard path

---
 rtl/race_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_race_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/race_sequencer.sv
// race_sequencer
//   Game-flow controller for the racer: TITLE -> COUNTDOWN -> RACE <-> PAUSE,
//   RACE -> CRASH -> TITLE. Owns lane, speed and distance score, and drives
//   the renderer scroll enable.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   S_TITLE   | idle title screen, waiting for SPACE
//   S_COUNT   | countdown digit shown, steps every FRAMES_SEC ticks
//   S_RACE    | racing: keys steer/accelerate, ticks add distance
//   S_PAUSE   | everything frozen until SPACE or ESC
//   S_CRASH   | crashed, waits CRASH_FRAMES ticks then back to title
//
// Ports
//   CLK, rst        clock, synchronous active-high reset
//   key_valid/code  decoded key strobe and code (1..6 meaningful)
//   frame_tick      one-cycle strobe per video frame
//   collision       level, car overlaps an obstacle
//   game_state      0 TITLE, 1 COUNTDOWN, 2 RACE, 3 PAUSE, 4 CRASH
//   countdown       digit shown during COUNTDOWN, else 0
//   lane, speed     player lane and speed
//   score           distance, saturating at 16'hFFFF
//   run             high only in RACE
module race_sequencer #(
  parameter int LANES        = 3,
  parameter int SPEED_MAX    = 9,
  parameter int COUNT_START  = 3,
  parameter int FRAMES_SEC   = 60,
  parameter int CRASH_FRAMES = 120
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [2:0]  key_code,
  input  logic        frame_tick,
  input  logic        collision,
  output logic [2:0]  game_state,
  output logic [1:0]  countdown,
  output logic [1:0]  lane,
  output logic [3:0]  speed,
  output logic [15:0] score,
  output logic        run
);

  localparam int CNT_MAX = (FRAMES_SEC > CRASH_FRAMES) ? FRAMES_SEC : CRASH_FRAMES;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [1:0]    LANE_INIT = 2'(LANES / 2);
  localparam logic [1:0]    LANE_LAST = 2'(LANES - 1);
  localparam logic [3:0]    SPEED_TOP = 4'(SPEED_MAX);
  localparam logic [1:0]    CD_INIT   = 2'(COUNT_START);
  localparam logic [CW-1:0] FS_LAST   = CW'(FRAMES_SEC - 1);
  localparam logic [CW-1:0] CR_LAST   = CW'(CRASH_FRAMES - 1);

  localparam logic [2:0] K_LEFT  = 3'd1;
  localparam logic [2:0] K_RIGHT = 3'd2;
  localparam logic [2:0] K_UP    = 3'd3;
  localparam logic [2:0] K_DOWN  = 3'd4;
  localparam logic [2:0] K_SPACE = 3'd5;
  localparam logic [2:0] K_ESC   = 3'd6;

  typedef enum logic [2:0] {
    S_TITLE = 3'd0,
    S_COUNT = 3'd1,
    S_RACE  = 3'd2,
    S_PAUSE = 3'd3,
    S_CRASH = 3'd4
  } state_t;

  state_t        state_q;
  logic [CW-1:0] fcnt_q;
  logic [1:0]    countdown_q;
  logic [1:0]    lane_q;
  logic [3:0]    speed_q;
  logic [15:0]   score_q;
  logic          run_q;

  // Without a valid strobe the code is treated as "no key".
  logic [2:0]  key_d;
  logic [16:0] score_sum_d;
  logic [15:0] score_d;

  assign key_d       = key_valid ? key_code : 3'd0;
  assign score_sum_d = {1'b0, score_q} + {13'd0, speed_q};
  assign score_d     = score_sum_d[16] ? 16'hFFFF : score_sum_d[15:0];

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= S_TITLE;
      fcnt_q      <= '0;
      countdown_q <= 2'd0;
      lane_q      <= LANE_INIT;
      speed_q     <= 4'd0;
      score_q     <= 16'd0;
      run_q       <= 1'b0;
    end else begin
      case (state_q)
        S_TITLE: begin
          if (key_d == K_SPACE) begin
            state_q     <= S_COUNT;
            countdown_q <= CD_INIT;
            fcnt_q      <= '0;
            lane_q      <= LANE_INIT;
            speed_q     <= 4'd0;
            score_q     <= 16'd0;
          end
        end
        S_COUNT: begin
          if (key_d == K_ESC) begin
            state_q     <= S_TITLE;
            countdown_q <= 2'd0;
          end else if (frame_tick) begin
            if (fcnt_q == FS_LAST) begin
              fcnt_q <= '0;
              if (countdown_q == 2'd1) begin
                state_q     <= S_RACE;
                countdown_q <= 2'd0;
                run_q       <= 1'b1;
              end else begin
                countdown_q <= countdown_q - 2'd1;
              end
            end else begin
              fcnt_q <= fcnt_q + 1'b1;
            end
          end
        end
        S_RACE: begin
          // Distance uses the speed from before any key in this cycle.
          if (frame_tick) score_q <= score_d;
          if (collision) begin
            state_q <= S_CRASH;
            speed_q <= 4'd0;
            fcnt_q  <= '0;
            run_q   <= 1'b0;
          end else begin
            case (key_d)
              K_LEFT:  if (lane_q != 2'd0)     lane_q  <= lane_q - 2'd1;
              K_RIGHT: if (lane_q < LANE_LAST) lane_q  <= lane_q + 2'd1;
              K_UP:    if (speed_q < SPEED_TOP) speed_q <= speed_q + 4'd1;
              K_DOWN:  if (speed_q != 4'd0)    speed_q <= speed_q - 4'd1;
              K_SPACE: begin
                state_q <= S_PAUSE;
                run_q   <= 1'b0;
              end
              K_ESC: begin
                state_q <= S_TITLE;
                run_q   <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        S_PAUSE: begin
          if (key_d == K_SPACE) begin
            state_q <= S_RACE;
            run_q   <= 1'b1;
          end else if (key_d == K_ESC) begin
            state_q <= S_TITLE;
          end
        end
        S_CRASH: begin
          if (frame_tick) begin
            if (fcnt_q == CR_LAST) begin
              state_q <= S_TITLE;
              fcnt_q  <= '0;
            end else begin
              fcnt_q <= fcnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q     <= S_TITLE;
          countdown_q <= 2'd0;
          run_q       <= 1'b0;
        end
      endcase
    end
  end

  assign game_state = state_q;
  assign countdown  = countdown_q;
  assign lane       = lane_q;
  assign speed      = speed_q;
  assign score      = score_q;
  assign run        = run_q;

endmodule

// File: tb/tb_race_sequencer.sv
module tb_race_sequencer;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [2:0]  key_code = 3'd0;
  logic        frame_tick = 1'b0;
  logic        collision = 1'b0;
  logic [2:0]  game_state;
  logic [1:0]  countdown;
  logic [1:0]  lane;
  logic [3:0]  speed;
  logic [15:0] score;
  logic        run;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: game values as plain integers.
  int m_state, m_cd, m_fc, m_lane, m_speed, m_score;

  always #5 CLK = ~CLK;

  race_sequencer dut (
    .CLK(CLK), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .frame_tick(frame_tick), .collision(collision), .game_state(game_state),
    .countdown(countdown), .lane(lane), .speed(speed), .score(score), .run(run)
  );

  task automatic model_reset();
    m_state = 0; m_cd = 0; m_fc = 0; m_lane = 1; m_speed = 0; m_score = 0;
  endtask

  task automatic model_step(input bit r, input bit kv, input int kc, input bit ft, input bit col);
    int k;
    k = kv ? kc : 0;
    if (r) begin
      model_reset();
      return;
    end
    case (m_state)
      0: if (k == 5) begin
           m_state = 1; m_cd = 3; m_fc = 0; m_lane = 1; m_speed = 0; m_score = 0;
         end
      1: if (k == 6) begin
           m_state = 0; m_cd = 0;
         end else if (ft) begin
           if (m_fc == 59) begin
             m_fc = 0;
             m_cd = m_cd - 1;
             if (m_cd == 0) m_state = 2;
           end else m_fc = m_fc + 1;
         end
      2: begin
           if (ft) m_score = (m_score + m_speed > 65535) ? 65535 : m_score + m_speed;
           if (col) begin
             m_state = 4; m_speed = 0; m_fc = 0;
           end else begin
             case (k)
               1: m_lane  = (m_lane > 0) ? m_lane - 1 : 0;
               2: m_lane  = (m_lane < 2) ? m_lane + 1 : 2;
               3: m_speed = (m_speed < 9) ? m_speed + 1 : 9;
               4: m_speed = (m_speed > 0) ? m_speed - 1 : 0;
               5: m_state = 3;
               6: m_state = 0;
               default: ;
             endcase
           end
         end
      3: if (k == 5) m_state = 2; else if (k == 6) m_state = 0;
      4: if (ft) begin
           if (m_fc == 119) begin m_state = 0; m_fc = 0; end
           else m_fc = m_fc + 1;
         end
      default: m_state = 0;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("game_state", {29'd0, game_state}, m_state);
    chk("countdown",  {30'd0, countdown},  m_cd);
    chk("lane",       {30'd0, lane},       m_lane);
    chk("speed",      {28'd0, speed},      m_speed);
    chk("score",      {16'd0, score},      m_score);
    chk("run",        {31'd0, run},        (m_state == 2) ? 1 : 0);
  endtask

  // One clock: drive inputs, let DUT and model both consume them, check 1ns later.
  task automatic step(input bit r, input bit kv, input int kc, input bit ft, input bit col);
    rst = r; key_valid = kv; key_code = kc[2:0]; frame_tick = ft; collision = col;
    @(posedge CLK);
    model_step(r, kv, kc, ft, col);
    #1;
    rst = 1'b0; key_valid = 1'b0; key_code = 3'd0; frame_tick = 1'b0; collision = 1'b0;
    check_all();
  endtask

  task automatic key(input int kc);
    step(0, 1, kc, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0);
  endtask

  initial begin
    model_reset();
    // reset state
    step(1, 0, 0, 0, 0);
    chk("reset_state", {29'd0, game_state}, 0);
    chk("reset_lane",  {30'd0, lane}, 1);

    // T1 countdown 3,2,1 then RACE on tick 180
    key(5);
    chk("t1_cd3", {30'd0, countdown}, 3);
    ticks(59);
    chk("t1_still3", {30'd0, countdown}, 3);
    ticks(1);
    chk("t1_cd2", {30'd0, countdown}, 2);
    ticks(60);
    chk("t1_cd1", {30'd0, countdown}, 1);
    ticks(59);
    chk("t1_not_race", {29'd0, game_state}, 1);
    ticks(1);
    chk("t1_race", {29'd0, game_state}, 2);
    chk("t1_cd0", {30'd0, countdown}, 0);
    chk("t1_run", {31'd0, run}, 1);

    // T2 lane saturation
    for (int i = 0; i < 3; i++) begin key(1); chk("t2_left", {30'd0, lane}, 0); end
    key(2); chk("t2_r1", {30'd0, lane}, 1);
    for (int i = 0; i < 4; i++) begin key(2); chk("t2_right", {30'd0, lane}, 2); end

    // T3 speed saturation and score
    for (int i = 0; i < 12; i++) key(3);
    chk("t3_speed9", {28'd0, speed}, 9);
    ticks(10);
    chk("t3_score90", {16'd0, score}, 90);
    for (int i = 0; i < 12; i++) key(4);
    chk("t3_speed0", {28'd0, speed}, 0);

    // T4 key and tick same cycle, then pause freezes everything
    for (int i = 0; i < 5; i++) key(3);
    step(0, 1, 3, 1, 0);
    chk("t4_score95", {16'd0, score}, 95);
    chk("t4_speed6", {28'd0, speed}, 6);
    key(5);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1);
    chk("t4_pause", {29'd0, game_state}, 3);
    chk("t4_score_held", {16'd0, score}, 95);
    chk("t4_speed_held", {28'd0, speed}, 6);
    key(5);

    // T5 collision beats RIGHT; crash lasts 120 ticks
    key(1);
    step(0, 1, 2, 0, 1);
    chk("t5_crash", {29'd0, game_state}, 4);
    chk("t5_lane", {30'd0, lane}, 1);
    chk("t5_speed0", {28'd0, speed}, 0);
    ticks(119);
    chk("t5_still_crash", {29'd0, game_state}, 4);
    ticks(1);
    chk("t5_title", {29'd0, game_state}, 0);
    chk("t5_score_held", {16'd0, score}, 95);

    // T6 reset in RACE
    key(5);
    ticks(180);
    key(2);
    for (int i = 0; i < 5; i++) key(3);
    ticks(60);
    key(3); key(3);
    chk("t6_score300", {16'd0, score}, 300);
    chk("t6_speed7", {28'd0, speed}, 7);
    step(1, 0, 0, 0, 0);
    chk("t6_state", {29'd0, game_state}, 0);
    chk("t6_lane", {30'd0, lane}, 1);
    chk("t6_score0", {16'd0, score}, 0);

    // score saturation
    key(5);
    ticks(180);
    for (int i = 0; i < 9; i++) key(3);
    ticks(7300);
    chk("sat_score", {16'd0, score}, 65535);
    key(6);
    chk("esc_keeps_score", {16'd0, score}, 65535);

    // randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      int r, kc;
      r = $urandom_range(0, 31);
      if (r < 2) kc = 6;
      else if (r < 9) kc = 5;
      else kc = $urandom_range(0, 7);
      step($urandom_range(0, 2999) == 0, $urandom_range(0, 3) == 0, kc,
           $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
